// File: rtl/load_writeback_unit_pkg.sv
// Shared types and constants for the load writeback path: RV32I load funct3 codes,
// FSM states and default widths.
package load_writeback_unit_pkg;

    localparam int XLEN_DEF           = 32;
    localparam int REG_ADDR_W_DEF     = 5;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } lwb_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_writeback_unit_if.sv
// Bundle of the load request, ALU writeback, data-memory and register-file signals.
// The unit sits on the slave modport; the surrounding core/memory drives the master side.
interface load_writeback_unit_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [XLEN-1:0]       ld_addr;
    logic [2:0]            ld_funct3;
    logic [REG_ADDR_W-1:0] ld_rd;

    logic                  alu_wb_valid;
    logic [REG_ADDR_W-1:0] alu_wb_rd;
    logic [XLEN-1:0]       alu_wb_data;
    logic                  alu_wb_stall;

    logic                  dmem_req;
    logic [XLEN-1:0]       dmem_addr;
    logic                  dmem_ack;
    logic [XLEN-1:0]       dmem_rdata;

    logic                  rf_write_en;
    logic [REG_ADDR_W-1:0] rf_dst_reg;
    logic [XLEN-1:0]       rf_data_in;

    logic                  ld_error;
    logic                  busy;

    modport slave (
        input  ld_valid, ld_addr, ld_funct3, ld_rd,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  dmem_ack, dmem_rdata,
        output ld_ready, alu_wb_stall, dmem_req, dmem_addr,
        output rf_write_en, rf_dst_reg, rf_data_in, ld_error, busy
    );

    modport master (
        output ld_valid, ld_addr, ld_funct3, ld_rd,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output dmem_ack, dmem_rdata,
        input  ld_ready, alu_wb_stall, dmem_req, dmem_addr,
        input  rf_write_en, rf_dst_reg, rf_data_in, ld_error, busy
    );
endinterface

// File: rtl/load_writeback_unit_extract.sv
// load_extract: selects the byte/half/word lane of a fetched word and sign/zero extends it.
// Purely combinational; misaligned halves/words are aligned down (half lane = lane[1]).
module load_extract
    import load_writeback_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        data   = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/load_writeback_unit.sv
// Load writeback unit: accepts a load, fetches over dmem req/ack, extends and writes the
// register file; ALU writebacks share the port with load priority. Optional macro:
// LOAD_MISALIGN_TRAP_EN (misaligned LH/LHU/LW raise ld_error instead of aligning down).
module load_writeback_unit
    import load_writeback_unit_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    load_writeback_unit_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lwb_state_e            state_q, state_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  trap;
    logic [XLEN-1:0]       ext_data;

    load_extract #(.XLEN(XLEN)) u_extract (
        .word   (data_q),
        .lane   (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (ext_data)
    );

    always_comb begin
`ifdef LOAD_MISALIGN_TRAP_EN
        trap = (((bus.ld_funct3 == F3_LH) || (bus.ld_funct3 == F3_LHU)) && bus.ld_addr[0]) ||
               ((bus.ld_funct3 == F3_LW) && (bus.ld_addr[1:0] != 2'b00));
`else
        trap = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ld_valid) begin
                    addr_d   = bus.ld_addr;
                    funct3_d = bus.ld_funct3;
                    rd_d     = bus.ld_rd;
                    cnt_d    = '0;
                    if (!f3_legal(bus.ld_funct3) || trap) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.dmem_ack) begin
                    data_d  = bus.dmem_rdata;
                    cnt_d   = '0;
                    state_d = ST_WB;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: nothing is written and the captured operands are simply stale.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    logic                  in_wb;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_dst;
    logic [XLEN-1:0]       rf_dat;

    assign in_wb = (state_q == ST_WB);

    // The load owns the write port in WB even when rd==0; the ALU stalls regardless.
    always_comb begin
        rf_we  = 1'b0;
        rf_dst = '0;
        rf_dat = '0;
        if (in_wb) begin
            rf_we  = (rd_q != '0);
            rf_dst = rd_q;
            rf_dat = ext_data;
        end else if (bus.alu_wb_valid) begin
            rf_we  = (bus.alu_wb_rd != '0);
            rf_dst = bus.alu_wb_rd;
            rf_dat = bus.alu_wb_data;
        end
    end

    assign bus.rf_write_en  = rf_we;
    assign bus.rf_dst_reg   = rf_dst;
    assign bus.rf_data_in   = rf_dat;
    assign bus.alu_wb_stall = in_wb && bus.alu_wb_valid;
    assign bus.ld_ready     = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.dmem_req     = (state_q == ST_REQ);
    assign bus.dmem_addr    = (state_q == ST_REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign bus.ld_error     = err_q;
endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: inputs change and outputs are checked around the
// falling clock edge; expected values are hand-computed constants.
module tb_load_writeback_unit;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    load_writeback_unit_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

    load_writeback_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data,
                            input logic exp_we);
        chk({tag, "_ready"}, 32'(bus.ld_ready), 32'd1);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = addr;
        bus.ld_funct3 = f3;
        bus.ld_rd     = rd;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk({tag, "_req1"}, 32'(bus.dmem_req), 32'd1);
        chk({tag, "_daddr"}, bus.dmem_addr, exp_addr);
        chk({tag, "_notready"}, 32'(bus.ld_ready), 32'd0);
        @(negedge clk);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
        #1;
        chk({tag, "_req2"}, 32'(bus.dmem_req), 32'd1);
        chk({tag, "_we_in_req"}, 32'(bus.rf_write_en), 32'd0);
        @(negedge clk);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        chk({tag, "_we"}, 32'(bus.rf_write_en), 32'(exp_we));
        chk({tag, "_dst"}, 32'(bus.rf_dst_reg), 32'(rd));
        chk({tag, "_data"}, bus.rf_data_in, exp_data);
        chk({tag, "_reqlow"}, 32'(bus.dmem_req), 32'd0);
        @(negedge clk);
        chk({tag, "_we_done"}, 32'(bus.rf_write_en), 32'd0);
        chk({tag, "_idle"}, 32'(bus.ld_ready), 32'd1);
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        bus.ld_valid     = 1'b0;
        bus.ld_addr      = '0;
        bus.ld_funct3    = '0;
        bus.ld_rd        = '0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_rd    = '0;
        bus.alu_wb_data  = '0;
        bus.dmem_ack     = 1'b0;
        bus.dmem_rdata   = '0;

        #2;
        chk("rst_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_we", 32'(bus.rf_write_en), 32'd0);
        chk("rst_err", 32'(bus.ld_error), 32'd0);
        chk("rst_daddr", bus.dmem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_load("lb103",  32'h103, 3'b000, 5'd3, 32'h80FF1234, 32'h100, 32'hFFFFFF80, 1'b1);
        run_load("lhu102", 32'h102, 3'b101, 5'd9, 32'h9ABC5678, 32'h100, 32'h00009ABC, 1'b1);
        run_load("lh102",  32'h102, 3'b001, 5'd10, 32'h9ABC5678, 32'h100, 32'hFFFF9ABC, 1'b1);
        run_load("lh100",  32'h100, 3'b001, 5'd11, 32'h9ABC5678, 32'h100, 32'h00005678, 1'b1);
        run_load("lbu101", 32'h101, 3'b100, 5'd12, 32'h9ABC5678, 32'h100, 32'h00000056, 1'b1);
        run_load("lb100",  32'h100, 3'b000, 5'd13, 32'h000000F0, 32'h100, 32'hFFFFFFF0, 1'b1);
        run_load("lw204",  32'h204, 3'b010, 5'd14, 32'hCAFEF00D, 32'h204, 32'hCAFEF00D, 1'b1);

        // ALU writes straight through while idle; rd==0 suppresses the write.
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd7;
        bus.alu_wb_data  = 32'h00001234;
        #1;
        chk("alu_idle_we", 32'(bus.rf_write_en), 32'd1);
        chk("alu_idle_dst", 32'(bus.rf_dst_reg), 32'd7);
        chk("alu_idle_data", bus.rf_data_in, 32'h00001234);
        chk("alu_idle_stall", 32'(bus.alu_wb_stall), 32'd0);
        bus.alu_wb_rd = 5'd0;
        #1;
        chk("alu_rd0_we", 32'(bus.rf_write_en), 32'd0);
        bus.alu_wb_valid = 1'b0;
        @(negedge clk);

        // LW to x0 with a concurrent ALU write during WB.
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h200;
        bus.ld_funct3 = 3'b010;
        bus.ld_rd     = 5'd0;
        @(negedge clk);
        bus.ld_valid   = 1'b0;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("lwx0_req", 32'(bus.dmem_req), 32'd1);
        @(negedge clk);
        bus.dmem_ack     = 1'b0;
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd5;
        bus.alu_wb_data  = 32'h00000055;
        #1;
        chk("lwx0_wb_busy", 32'(bus.busy), 32'd1);
        chk("lwx0_wb_we", 32'(bus.rf_write_en), 32'd0);
        chk("lwx0_wb_stall", 32'(bus.alu_wb_stall), 32'd1);
        @(negedge clk);
        chk("lwx0_alu_we", 32'(bus.rf_write_en), 32'd1);
        chk("lwx0_alu_dst", 32'(bus.rf_dst_reg), 32'd5);
        chk("lwx0_alu_data", bus.rf_data_in, 32'h00000055);
        chk("lwx0_alu_stall", 32'(bus.alu_wb_stall), 32'd0);
        bus.alu_wb_valid = 1'b0;
        @(negedge clk);

        // Timeout: 255 REQ cycles without ack.
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h300;
        bus.ld_funct3 = 3'b010;
        bus.ld_rd     = 5'd4;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        for (int i = 1; i < 255; i++) @(negedge clk);
        chk("to_req_last", 32'(bus.dmem_req), 32'd1);
        chk("to_err_early", 32'(bus.ld_error), 32'd0);
        @(negedge clk);
        chk("to_err", 32'(bus.ld_error), 32'd1);
        chk("to_reqlow", 32'(bus.dmem_req), 32'd0);
        chk("to_ready", 32'(bus.ld_ready), 32'd1);
        chk("to_we", 32'(bus.rf_write_en), 32'd0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h12345678;
        @(negedge clk);
        chk("to_err_pulse", 32'(bus.ld_error), 32'd0);
        chk("late_ack_busy", 32'(bus.busy), 32'd0);
        chk("late_ack_we", 32'(bus.rf_write_en), 32'd0);
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_we2", 32'(bus.rf_write_en), 32'd0);

        // Reset while in REQ.
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h400;
        bus.ld_funct3 = 3'b010;
        bus.ld_rd     = 5'd6;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("mrst_req_before", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_req", 32'(bus.dmem_req), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_we", 32'(bus.rf_write_en), 32'd0);
        chk("mrst_ready", 32'(bus.ld_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Illegal funct3.
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h500;
        bus.ld_funct3 = 3'b011;
        bus.ld_rd     = 5'd8;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("ill_err", 32'(bus.ld_error), 32'd1);
        chk("ill_req", 32'(bus.dmem_req), 32'd0);
        chk("ill_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("ill_err_pulse", 32'(bus.ld_error), 32'd0);
        chk("ill_req2", 32'(bus.dmem_req), 32'd0);

`ifdef LOAD_MISALIGN_TRAP_EN
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h102;
        bus.ld_funct3 = 3'b010;
        bus.ld_rd     = 5'd15;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("mis_err", 32'(bus.ld_error), 32'd1);
        chk("mis_req", 32'(bus.dmem_req), 32'd0);
        chk("mis_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("mis_err_pulse", 32'(bus.ld_error), 32'd0);
`else
        run_load("lw102", 32'h102, 3'b010, 5'd15, 32'h11223344, 32'h100, 32'h11223344, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
